// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants, state/op encodings and decode helper for the mul/div sequencer.
package multdiv_sequencer_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [4:0] OP_RTYPE   = 5'b00000;
  localparam logic [4:0] ALU_MUL    = 5'b00110;
  localparam logic [4:0] ALU_DIV    = 5'b00111;
  localparam logic [4:0] REG_STATUS = 5'd30;

  localparam int EXC_MUL = 4;
  localparam int EXC_DIV = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_e;

  function automatic logic is_muldiv(input logic [4:0] opcode, input logic [4:0] alu_op);
    return (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
  endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Decode-side request, pipeline stall and regfile writeback handshake of the mul/div unit.
interface multdiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [4:0]       opcode;
  logic [4:0]       alu_op;
  logic [4:0]       rd;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             stall;
  logic             wb_valid;
  logic [4:0]       wb_reg;
  logic [WIDTH-1:0] wb_data;
  logic             wb_ack;

  modport master (
    output in_valid, opcode, alu_op, rd, operand_a, operand_b, flush, wb_ack,
    input  stall, wb_valid, wb_reg, wb_data
  );

  modport slave (
    input  in_valid, opcode, alu_op, rd, operand_a, operand_b, flush, wb_ack,
    output stall, wb_valid, wb_reg, wb_data
  );
endinterface

// File: rtl/multdiv_sequencer_iter.sv
// One-bit-per-cycle datapath: radix-2 Booth multiply or restoring divide on magnitudes.
// o_result / o_mul_ovf reflect the value after the step taken at the next edge.
module multdiv_sequencer_iter
  import multdiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_step,
  input  md_op_e           i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_mul_ovf
);

  md_op_e           r_op;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic [WIDTH:0]   r_m;
  logic             r_div_neg;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_qm1_nxt;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_ovf_bits;

  assign w_mag_a = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_mag_b = i_b[WIDTH-1] ? -i_b : i_b;

  always_comb begin
    w_sum     = r_acc;
    w_shl     = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    w_diff    = w_shl - r_m;
    w_acc_nxt = r_acc;
    w_q_nxt   = r_q;
    w_qm1_nxt = r_qm1;
    if (r_op == OP_MUL) begin
      unique case ({r_q[0], r_qm1})
        2'b01:   w_sum = r_acc + r_m;
        2'b10:   w_sum = r_acc - r_m;
        default: w_sum = r_acc;
      endcase
      // arithmetic shift right of {acc, q, q-1}
      w_acc_nxt = {w_sum[WIDTH], w_sum[WIDTH:1]};
      w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
      w_qm1_nxt = r_q[0];
    end else begin
      if (w_diff[WIDTH]) begin
        w_acc_nxt = w_shl;
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
      end else begin
        w_acc_nxt = w_diff;
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  // product bits [2W-1:W-1] must be a pure sign extension
  assign w_ovf_bits = {w_acc_nxt[WIDTH-1:0], w_q_nxt[WIDTH-1]};
  assign o_mul_ovf  = (w_ovf_bits != '0) && (w_ovf_bits != '1);
  assign o_result   = ((r_op == OP_DIV) && r_div_neg) ? -w_q_nxt : w_q_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op      <= OP_MUL;
      r_acc     <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_m       <= '0;
      r_div_neg <= 1'b0;
    end else if (i_start) begin
      r_op      <= i_op;
      r_acc     <= '0;
      r_qm1     <= 1'b0;
      r_div_neg <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      if (i_op == OP_MUL) begin
        r_q <= i_b;
        r_m <= {i_a[WIDTH-1], i_a};
      end else begin
        r_q <= w_mag_a;
        r_m <= {1'b0, w_mag_b};
      end
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      r_qm1 <= w_qm1_nxt;
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multicycle mul/div controller: accepts one op from decode, stalls the pipeline while
// iterating, then requests a regfile writeback of the result or an exception code.
//   state | meaning
//   IDLE  | waiting for a mul/div from decode
//   BUSY  | one datapath iteration per cycle, WIDTH iterations
//   DONE  | writeback request held until wb_ack
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int         WIDTH      = MD_WIDTH,
  parameter logic [4:0] STATUS_REG = REG_STATUS,
  parameter int         MUL_EXC    = EXC_MUL,
  parameter int         DIV_EXC    = EXC_DIV
) (
  input  logic              i_clk,
  input  logic              i_rst,
  multdiv_sequencer_if.slave md_if
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e        r_state;
  logic [CW-1:0]    r_count;
  md_op_e           r_op;
  logic [4:0]       r_rd;
  logic             r_div_ovf;
  logic             r_wb_valid;
  logic [4:0]       r_wb_reg;
  logic [WIDTH-1:0] r_wb_data;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic             w_mul_ovf;
  md_op_e           w_op;
  logic [WIDTH-1:0] w_result;

  assign w_accept   = md_if.in_valid & ~md_if.flush & (r_state == ST_IDLE)
                    & is_muldiv(md_if.opcode, md_if.alu_op);
  assign w_op       = (md_if.alu_op == ALU_DIV) ? OP_DIV : OP_MUL;
  assign w_div_zero = (md_if.operand_b == '0);
  assign w_div_ovf  = (md_if.operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (md_if.operand_b == '1);
  assign w_step     = (r_state == ST_BUSY) & ~md_if.flush;
  assign w_last     = (r_count == CW'(WIDTH - 1));

  multdiv_sequencer_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_accept),
    .i_step    (w_step),
    .i_op      (w_op),
    .i_a       (md_if.operand_a),
    .i_b       (md_if.operand_b),
    .o_result  (w_result),
    .o_mul_ovf (w_mul_ovf)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_op       <= OP_MUL;
      r_rd       <= '0;
      r_div_ovf  <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_reg   <= '0;
      r_wb_data  <= '0;
    end else if (md_if.flush) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_wb_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rd      <= md_if.rd;
            r_op      <= w_op;
            r_count   <= '0;
            r_div_ovf <= (w_op == OP_DIV) && w_div_ovf;
            // a zero divisor needs no iterations: report it right away
            if ((w_op == OP_DIV) && w_div_zero) begin
              r_state    <= ST_DONE;
              r_wb_valid <= 1'b1;
              r_wb_reg   <= STATUS_REG;
              r_wb_data  <= WIDTH'(DIV_EXC);
            end else begin
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_state    <= ST_DONE;
            r_wb_valid <= 1'b1;
            if ((r_op == OP_MUL) && w_mul_ovf) begin
              r_wb_reg  <= STATUS_REG;
              r_wb_data <= WIDTH'(MUL_EXC);
            end else if ((r_op == OP_DIV) && r_div_ovf) begin
              r_wb_reg  <= STATUS_REG;
              r_wb_data <= WIDTH'(DIV_EXC);
            end else begin
              r_wb_reg  <= r_rd;
              r_wb_data <= w_result;
            end
          end
        end
        ST_DONE: begin
          if (md_if.wb_ack) begin
            r_state    <= ST_IDLE;
            r_wb_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wb_valid <= 1'b0;
        end
      endcase
    end
  end

  assign md_if.stall    = (r_state != ST_IDLE) | w_accept;
  assign md_if.wb_valid = r_wb_valid;
  assign md_if.wb_reg   = r_wb_reg;
  assign md_if.wb_data  = r_wb_data;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed vector table, random ops against
// a plain-arithmetic reference model, and hand-written flush/reset/hold/ignore sequences.
module tb_multdiv_sequencer;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  multdiv_sequencer_if #(.WIDTH(W)) mif ();

  multdiv_sequencer #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .md_if (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit valid, input logic [4:0] opc, input logic [4:0] alu,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    mif.in_valid  = valid;
    mif.opcode    = opc;
    mif.alu_op    = alu;
    mif.rd        = rd;
    mif.operand_a = a;
    mif.operand_b = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, output logic [4:0] r,
                                output logic [31:0] d, output int lat);
    longint p;
    int     q;
    if (is_mul) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      lat = 33;
      if (p != longint'($signed(p[31:0]))) begin
        r = 5'd30;
        d = 32'd4;
      end else begin
        r = rd;
        d = p[31:0];
      end
    end else if (b == 32'd0) begin
      lat = 1;
      r   = 5'd30;
      d   = 32'd5;
    end else begin
      lat = 33;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r = 5'd30;
        d = 32'd5;
      end else begin
        q = $signed(a) / $signed(b);
        r = rd;
        d = q;
      end
    end
  endfunction

  // Issue one op with wb_ack held high, check latency, stall, writeback and release.
  task automatic run_op(input string tag, input bit is_mul, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [4:0] exp_reg,
                        input logic [31:0] exp_data, input int exp_lat);
    int lat;
    bit stall_ok;
    mif.wb_ack = 1'b1;
    drive(1'b1, 5'b00000, is_mul ? 5'b00110 : 5'b00111, rd, a, b);
    #1;
    check({tag, " accept_stall"}, 64'(mif.stall), 64'd1);
    tick();
    drive(1'b0, 5'b00000, 5'b00000, 5'd0, 32'd0, 32'd0);
    lat = 1;
    stall_ok = 1'b1;
    while (!mif.wb_valid && lat < 100) begin
      if (!mif.stall) stall_ok = 1'b0;
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy_stall"}, 64'(stall_ok && mif.stall), 64'd1);
    check({tag, " wb_reg"}, 64'(mif.wb_reg), 64'(exp_reg));
    check({tag, " wb_data"}, 64'(mif.wb_data), 64'(exp_data));
    tick();
    check({tag, " release"}, {62'd0, mif.wb_valid, mif.stall}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [4:0]  rd, er;
    logic [31:0] ed;
    int          el;
    bit          is_mul;
    int          sel;
    int          lat;
    bit          ok;
    logic [4:0]  hold_reg;
    logic [31:0] hold_data;

    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{1'b1, 32'd7,          32'hFFFF_FFFD, 5'd5,  5'd5,  32'hFFFF_FFEB, 33};
    vecs[1]  = '{1'b0, 32'hFFFF_FF9C,  32'd7,         5'd9,  5'd9,  32'hFFFF_FFF2, 33};
    vecs[2]  = '{1'b0, 32'd42,         32'd0,         5'd3,  5'd30, 32'd5,         1};
    vecs[3]  = '{1'b1, 32'h0001_0000,  32'h0001_0000, 5'd4,  5'd30, 32'd4,         33};
    vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  5'd30, 32'd5,         33};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'd1,         5'd1,  5'd1,  32'h8000_0000, 33};
    vecs[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd6,  5'd30, 32'd4,         33};
    vecs[7]  = '{1'b0, 32'd100,        32'hFFFF_FFF9, 5'd0,  5'd0,  32'hFFFF_FFF2, 33};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd31, 5'd31, 32'd1,         33};
    vecs[9]  = '{1'b0, 32'd0,          32'hFFFF_FFFB, 5'd2,  5'd2,  32'd0,         33};
    vecs[10] = '{1'b0, 32'hFFFF_FFF9,  32'd2,         5'd8,  5'd8,  32'hFFFF_FFFD, 33};
    vecs[11] = '{1'b1, 32'h4000_0000,  32'd2,         5'd10, 5'd30, 32'd4,         33};
    vecs[12] = '{1'b1, 32'hC000_0000,  32'd2,         5'd11, 5'd11, 32'h8000_0000, 33};
    vecs[13] = '{1'b0, 32'h8000_0000,  32'd1,         5'd12, 5'd12, 32'h8000_0000, 33};

    rst = 1'b1;
    mif.flush  = 1'b0;
    mif.wb_ack = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    tick();
    tick();
    check("reset_state", {mif.stall, mif.wb_valid, mif.wb_reg, mif.wb_data}, 64'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].is_mul, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp_reg, vecs[i].exp_data, vecs[i].exp_lat);

    for (int i = 0; i < 30; i++) begin
      is_mul = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        4: begin a = 32'($urandom_range(0, 65535)); b = 32'($urandom_range(0, 65535)) - 32'd32768; end
        default: ;
      endcase
      model(is_mul, a, b, rd, er, ed, el);
      run_op($sformatf("rnd%0d", i), is_mul, a, b, rd, er, ed, el);
    end

    // flush mid-operation
    mif.wb_ack = 1'b0;
    drive(1'b1, 5'b00000, 5'b00110, 5'd5, 32'd7, 32'd3);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    for (int k = 1; k < 10; k++) tick();
    mif.flush = 1'b1;
    tick();
    mif.flush = 1'b0;
    #1;
    check("flush_idle", {62'd0, mif.wb_valid, mif.stall}, 64'd0);
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (mif.wb_valid || mif.stall) ok = 1'b0;
      tick();
    end
    check("flush_no_wb", 64'(ok), 64'd1);

    // reset mid-operation
    drive(1'b1, 5'b00000, 5'b00111, 5'd9, 32'd1000, 32'd3);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    for (int k = 1; k < 5; k++) tick();
    rst = 1'b1;
    #1;
    check("reset_mid", {mif.stall, mif.wb_valid, mif.wb_reg, mif.wb_data}, 64'd0);
    #2;
    rst = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mif.wb_valid || mif.stall) ok = 1'b0;
    end
    check("reset_no_wb", 64'(ok), 64'd1);

    // writeback held while the regfile port is not granted
    mif.wb_ack = 1'b0;
    drive(1'b1, 5'b00000, 5'b00111, 5'd9, 32'hFFFF_FF9C, 32'd7);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    lat = 1;
    while (!mif.wb_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("hold_latency", 64'(lat), 64'd33);
    hold_reg  = mif.wb_reg;
    hold_data = mif.wb_data;
    check("hold_first", {27'd0, hold_reg, hold_data}, {27'd0, 5'd9, 32'hFFFF_FFF2});
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (!(mif.wb_valid && mif.stall && mif.wb_reg == 5'd9 && mif.wb_data == 32'hFFFF_FFF2))
        ok = 1'b0;
    end
    check("hold_stable", 64'(ok), 64'd1);
    mif.wb_ack = 1'b1;
    tick();
    mif.wb_ack = 1'b0;
    check("hold_release", {62'd0, mif.wb_valid, mif.stall}, 64'd0);

    // non mul/div instructions bypass the sequencer
    drive(1'b1, 5'b00000, 5'b00000, 5'd4, 32'd1, 32'd2);
    #1;
    check("add_no_stall", 64'(mif.stall), 64'd0);
    tick();
    drive(1'b1, 5'b00101, 5'b00110, 5'd4, 32'd1, 32'd2);
    #1;
    check("addi_no_stall", 64'(mif.stall), 64'd0);
    tick();
    // flush beats accept
    drive(1'b1, 5'b00000, 5'b00110, 5'd4, 32'd1, 32'd2);
    mif.flush = 1'b1;
    #1;
    check("flush_beats_accept", 64'(mif.stall), 64'd0);
    tick();
    mif.flush = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (mif.wb_valid || mif.stall) ok = 1'b0;
      tick();
    end
    check("ignored_stay_idle", 64'(ok), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
